// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and its MDU sequencer.
package hazard_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       use_rs,
                                     input logic       use_rt);
    return (r != REG_ZERO) && ((r == rs && use_rs) || (r == rt && use_rt));
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Busy/done timing for the multi-cycle mult/div unit.
//   state   | meaning
//   MD_IDLE | no MDU op in flight
//   MD_BUSY | op in flight; cnt_q counts down to the final (done) cycle
module mdu_sequencer
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  localparam int MAX_CYC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_BITS = $clog2(MAX_CYC);

  md_state_e           state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_load_d;
  logic                done_q;

  assign cnt_load_d = is_div_i ? CNT_BITS'(DIV_CYCLES - 1) : CNT_BITS'(MUL_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= cnt_load_d;
          end
        end
        MD_BUSY: begin
          if (cnt_q == '0) begin
            // A start in the done cycle reloads with no idle gap.
            if (start_i) begin
              cnt_q <= cnt_load_d;
            end else begin
              state_q <= MD_IDLE;
            end
          end else begin
            cnt_q  <= cnt_q - CNT_BITS'(1);
            done_q <= (cnt_q == CNT_BITS'(1));
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush decisions for hazards forwarding cannot cover, plus
// MDU sequencing and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_IsBranch,
  input  logic             ID_BranchTaken,
  input  logic             ID_MdStart,
  input  logic             ID_MdIsDiv,
  input  logic             ID_MdUse,
  input  logic [4:0]       EX_writeimport,
  input  logic             EXRegWr,
  input  logic             EX_MemRead,
  input  logic [4:0]       ME_writeimport,
  input  logic             ME_MemRead,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MdBusy,
  output logic             MdDone,
  output logic [CNT_W-1:0] StallCnt
);

  logic ex_match, me_match;
  logic lu, bex, bme, md, stall;
  logic [CNT_W-1:0] stall_cnt_q;

  assign ex_match = reg_match(EX_writeimport, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt);
  assign me_match = reg_match(ME_writeimport, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt);

  assign lu    = EX_MemRead && EXRegWr && ex_match;
  assign bex   = ID_IsBranch && EXRegWr && ex_match;
  assign bme   = ID_IsBranch && ME_MemRead && me_match;
  assign md    = ID_MdUse && MdBusy && !MdDone;
  assign stall = lu | bex | bme | md;

  assign PC_Wr      = !stall;
  assign IFID_Wr    = !stall;
  assign IDEX_Flush = stall;
  assign IFID_Flush = ID_BranchTaken && !stall;

  mdu_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (ID_MdStart && !stall),
    .is_div_i(ID_MdIsDiv),
    .busy_o  (MdBusy),
    .done_o  (MdDone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational hazard vectors plus MDU,
// reset and counter-saturation sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] ID_Rs = '0, ID_Rt = '0;
  logic       ID_UsesRs = 0, ID_UsesRt = 0, ID_IsBranch = 0, ID_BranchTaken = 0;
  logic       ID_MdStart = 0, ID_MdIsDiv = 0, ID_MdUse = 0;
  logic [4:0] EX_writeimport = '0, ME_writeimport = '0;
  logic       EXRegWr = 0, EX_MemRead = 0, ME_MemRead = 0;

  logic        PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, MdBusy, MdDone;
  logic [31:0] StallCnt;
  logic        s_PC_Wr, s_IFID_Wr, s_IFID_Flush, s_IDEX_Flush, s_MdBusy, s_MdDone;
  logic [3:0]  s_StallCnt;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
    .ID_MdStart(ID_MdStart), .ID_MdIsDiv(ID_MdIsDiv), .ID_MdUse(ID_MdUse),
    .EX_writeimport(EX_writeimport), .EXRegWr(EXRegWr), .EX_MemRead(EX_MemRead),
    .ME_writeimport(ME_writeimport), .ME_MemRead(ME_MemRead),
    .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .MdBusy(MdBusy), .MdDone(MdDone), .StallCnt(StallCnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
    .ID_MdStart(ID_MdStart), .ID_MdIsDiv(ID_MdIsDiv), .ID_MdUse(ID_MdUse),
    .EX_writeimport(EX_writeimport), .EXRegWr(EXRegWr), .EX_MemRead(EX_MemRead),
    .ME_writeimport(ME_writeimport), .ME_MemRead(ME_MemRead),
    .PC_Wr(s_PC_Wr), .IFID_Wr(s_IFID_Wr), .IFID_Flush(s_IFID_Flush), .IDEX_Flush(s_IDEX_Flush),
    .MdBusy(s_MdBusy), .MdDone(s_MdDone), .StallCnt(s_StallCnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, br, taken;
    logic [4:0] ex_reg;
    logic       ex_wr, ex_rd;
    logic [4:0] me_reg;
    logic       me_rd, md_use;
    logic       pc_wr, ifid_fl, idex_fl;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0;
    ID_IsBranch = 0; ID_BranchTaken = 0;
    ID_MdStart = 0; ID_MdIsDiv = 0; ID_MdUse = 0;
    EX_writeimport = '0; EXRegWr = 0; EX_MemRead = 0;
    ME_writeimport = '0; ME_MemRead = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    #1;
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  initial begin
    logic [31:0] exp_cnt;
    logic        saw_done;

    //            name         rs    rt  urs urt br tk  ex  wr rd  me  mrd mdu  pc fl idex
    vecs[0]  = '{"idle",       5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0,  0, 0,  1, 0, 0};
    vecs[1]  = '{"lu_rs",      5'd2, 5'd0, 1, 0, 0, 0, 5'd2, 1, 1, 5'd0,  0, 0,  0, 0, 1};
    vecs[2]  = '{"lu_unused",  5'd2, 5'd0, 0, 0, 0, 0, 5'd2, 1, 1, 5'd0,  0, 0,  1, 0, 0};
    vecs[3]  = '{"lu_rt",      5'd0, 5'd7, 0, 1, 0, 0, 5'd7, 1, 1, 5'd0,  0, 0,  0, 0, 1};
    vecs[4]  = '{"lu_r0",      5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd0,  0, 0,  1, 0, 0};
    vecs[5]  = '{"bex_alu",    5'd3, 5'd0, 1, 0, 1, 1, 5'd3, 1, 0, 5'd0,  0, 0,  0, 0, 1};
    vecs[6]  = '{"bex_r0",     5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 1, 0, 5'd0,  0, 0,  1, 1, 0};
    vecs[7]  = '{"bme",        5'd0, 5'd5, 0, 1, 1, 1, 5'd0, 0, 0, 5'd5,  1, 0,  0, 0, 1};
    vecs[8]  = '{"me_nobr",    5'd0, 5'd5, 0, 1, 0, 0, 5'd0, 0, 0, 5'd5,  1, 0,  1, 0, 0};
    vecs[9]  = '{"alu_nobr",   5'd3, 5'd0, 1, 0, 0, 0, 5'd3, 1, 0, 5'd0,  0, 0,  1, 0, 0};
    vecs[10] = '{"lu_both",    5'd9, 5'd9, 1, 1, 0, 1, 5'd9, 1, 1, 5'd0,  0, 0,  0, 0, 1};
    vecs[11] = '{"br_taken",   5'd4, 5'd6, 1, 1, 1, 1, 5'd8, 1, 0, 5'd10, 1, 0,  1, 1, 0};
    vecs[12] = '{"mduse_idle", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0,  0, 1,  1, 0, 0};
    vecs[13] = '{"bme_r0",     5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 0, 0, 5'd0,  1, 0,  1, 0, 0};

    // Reset values with all inputs low
    clear_inputs();
    #2;
    chk("rst_busy", {31'd0, MdBusy}, 32'd0);
    chk("rst_done", {31'd0, MdDone}, 32'd0);
    chk("rst_cnt", StallCnt, 32'd0);
    chk("rst_pcwr", {31'd0, PC_Wr}, 32'd1);
    chk("rst_ifidwr", {31'd0, IFID_Wr}, 32'd1);
    chk("rst_flush", {30'd0, IFID_Flush, IDEX_Flush}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();

    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt;
      ID_UsesRs = vecs[i].use_rs; ID_UsesRt = vecs[i].use_rt;
      ID_IsBranch = vecs[i].br; ID_BranchTaken = vecs[i].taken;
      EX_writeimport = vecs[i].ex_reg; EXRegWr = vecs[i].ex_wr; EX_MemRead = vecs[i].ex_rd;
      ME_writeimport = vecs[i].me_reg; ME_MemRead = vecs[i].me_rd;
      ID_MdUse = vecs[i].md_use;
      #1;
      chk({vecs[i].name, ".pc_wr"}, {31'd0, PC_Wr}, {31'd0, vecs[i].pc_wr});
      chk({vecs[i].name, ".ifid_wr"}, {31'd0, IFID_Wr}, {31'd0, vecs[i].pc_wr});
      chk({vecs[i].name, ".ifid_flush"}, {31'd0, IFID_Flush}, {31'd0, vecs[i].ifid_fl});
      chk({vecs[i].name, ".idex_flush"}, {31'd0, IDEX_Flush}, {31'd0, vecs[i].idex_fl});
      if (vecs[i].idex_fl) exp_cnt++;
      step();
      chk({vecs[i].name, ".stallcnt"}, StallCnt, exp_cnt);
    end

    // Load feeding a taken branch: bex then bme, redirect only afterwards
    do_reset();
    ID_Rt = 5'd5; ID_UsesRt = 1; ID_IsBranch = 1; ID_BranchTaken = 1;
    EX_writeimport = 5'd5; EXRegWr = 1; EX_MemRead = 1;
    #1;
    chk("ldbr.c1_pcwr", {31'd0, PC_Wr}, 32'd0);
    chk("ldbr.c1_flush", {31'd0, IFID_Flush}, 32'd0);
    step();
    EX_writeimport = 5'd0; EXRegWr = 0; EX_MemRead = 0;
    ME_writeimport = 5'd5; ME_MemRead = 1;
    #1;
    chk("ldbr.c2_pcwr", {31'd0, PC_Wr}, 32'd0);
    chk("ldbr.c2_flush", {31'd0, IFID_Flush}, 32'd0);
    step();
    ME_writeimport = 5'd0; ME_MemRead = 0;
    #1;
    chk("ldbr.c3_pcwr", {31'd0, PC_Wr}, 32'd1);
    chk("ldbr.c3_flush", {31'd0, IFID_Flush}, 32'd1);
    chk("ldbr.cnt", StallCnt, 32'd2);

    // Divide latency with a dependent mflo arriving at t+3
    do_reset();
    ID_MdStart = 1; ID_MdIsDiv = 1; ID_MdUse = 1;
    #1;
    chk("div.t_pcwr", {31'd0, PC_Wr}, 32'd1);
    chk("div.t_busy", {31'd0, MdBusy}, 32'd0);
    step();
    ID_MdStart = 0; ID_MdIsDiv = 0; ID_MdUse = 0;
    for (int k = 1; k <= 16; k++) begin
      ID_MdUse = (k >= 3);
      #1;
      chk($sformatf("div.busy%0d", k), {31'd0, MdBusy}, 32'd1);
      chk($sformatf("div.done%0d", k), {31'd0, MdDone}, (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("div.pcwr%0d", k), {31'd0, PC_Wr}, (k >= 3 && k < 16) ? 32'd0 : 32'd1);
      step();
    end
    ID_MdUse = 0;
    #1;
    chk("div.end_busy", {31'd0, MdBusy}, 32'd0);
    chk("div.end_done", {31'd0, MdDone}, 32'd0);
    chk("div.cnt", StallCnt, 32'd13);

    // Back-to-back multiplies
    do_reset();
    ID_MdStart = 1; ID_MdUse = 1;
    #1;
    step();
    for (int k = 1; k <= 8; k++) begin
      if (k >= 5) begin
        ID_MdStart = 0; ID_MdUse = 0;
      end
      #1;
      chk($sformatf("b2b.busy%0d", k), {31'd0, MdBusy}, 32'd1);
      chk($sformatf("b2b.done%0d", k), {31'd0, MdDone}, (k == 4 || k == 8) ? 32'd1 : 32'd0);
      if (k <= 4)
        chk($sformatf("b2b.pcwr%0d", k), {31'd0, PC_Wr}, (k < 4) ? 32'd0 : 32'd1);
      step();
    end
    #1;
    chk("b2b.end_busy", {31'd0, MdBusy}, 32'd0);
    chk("b2b.cnt", StallCnt, 32'd3);

    // Asynchronous reset in the middle of a divide
    do_reset();
    ID_MdStart = 1; ID_MdIsDiv = 1;
    #1;
    step();
    ID_MdStart = 0; ID_MdIsDiv = 0; ID_MdUse = 1;
    for (int k = 1; k < 5; k++) step();
    chk("mid.pre_busy", {31'd0, MdBusy}, 32'd1);
    chk("mid.pre_cnt", StallCnt, 32'd4);
    #2;
    clear_inputs();
    rst_n = 0;
    #1;
    chk("mid.busy", {31'd0, MdBusy}, 32'd0);
    chk("mid.done", {31'd0, MdDone}, 32'd0);
    chk("mid.cnt", StallCnt, 32'd0);
    chk("mid.pcwr", {31'd0, PC_Wr}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (MdDone || MdBusy) saw_done = 1;
    end
    chk("mid.no_done", {31'd0, saw_done}, 32'd0);

    // Counter saturation on the narrow-counter instance
    do_reset();
    chk("sat.rst", {28'd0, s_StallCnt}, 32'd0);
    ID_Rs = 5'd2; ID_UsesRs = 1; EX_writeimport = 5'd2; EXRegWr = 1; EX_MemRead = 1;
    for (int k = 0; k < 15; k++) step();
    chk("sat.15", {28'd0, s_StallCnt}, 32'd15);
    for (int k = 0; k < 5; k++) step();
    chk("sat.hold", {28'd0, s_StallCnt}, 32'd15);
    chk("sat.wide", StallCnt, 32'd20);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
